usb_nrzi_line_engine: RTL
=========================

// Module: usb_nrzi_line_engine
// PURPOSE
//  Parametrised USB FS/LS line engine, successor to the host trans-receiver. Serialises a bit
//  stream to D+/D- with SYNC, NRZI, bit stuffing and EOP; decodes received line with clock
//  recovery, SYNC detect, NRZI decode, destuffing and EOP/stuff-error detection.
//  Sits between the PISO/SIPO bit streams and the pad; split in/out/oe replaces the inout bus.
// PARAMETERS
//  CLK_PER_BIT  4  clock cycles per USB bit time; min 4.
//  SYNC_BITS    8  SYNC length in bits; 8 or 32 only.
//  STUFF_LIMIT  6  consecutive 1s before a stuffed 0 (tx) / mandatory 0 (rx).
//  EOP_SE0_BITS 2  SE0 bit times driven at tx EOP.
// PORTS
//  clock        in   1  single clock for the whole block.
//  reset        in   1  synchronous reset, active-high.
//  speed_low    in   1  1: LS (J={dp,dm}=01, K=10); 0: FS (J=10, K=01). Latched only in TX_IDLE/RX_IDLE.
//  tx_start     in   1  pulse in TX_IDLE: begin packet; ignored elsewhere.
//  tx_bit       in   1  payload bit (LSB-first stream from PISO).
//  tx_bit_val   in   1  tx_bit valid.
//  tx_bit_last  in   1  with val: final payload bit.
//  tx_ready     out  1  1 when a payload bit is accepted this cycle (val&ready = transfer).
//  tx_busy      out  1  1 from tx_start acceptance until EOP J bit completes.
//  tx_underrun  out  1  one-cycle pulse: no valid bit at a payload slot.
//  usb_out      out  2  {dp,dm} driven value.
//  usb_oe       out  1  pad output enable; equals tx_busy.
//  usb_in       in   2  {dp,dm} sampled line (already synchronised upstream).
//  rx_bit       out  1  decoded, destuffed bit.
//  rx_bit_val   out  1  one-cycle strobe per decoded bit.
//  rx_active    out  1  1 from SYNC end (KK) until EOP/error.
//  rx_eop       out  1  one-cycle pulse on EOP detection.
//  rx_stuff_err out  1  one-cycle pulse: 1 received where stuffed 0 required.
// BEHAVIOUR
//  Reset: TX_IDLE, RX_IDLE; usb_out=J(FS), usb_oe=0, all strobes/flags 0, counters 0.
//  Bit timer: TX counter 0..CLK_PER_BIT-1; line value changes only when counter wraps to 0.
//  TX FSM: TX_IDLE -tx_start-> TX_SYNC -> TX_DATA -> TX_EOP -> TX_J -> TX_IDLE.
//   TX_IDLE: usb_out=J, oe=0. tx_start -> counter cleared, oe=1 next cycle.
//   TX_SYNC: SYNC_BITS encoded bits: SYNC_BITS-1 zeros then one 1 (line KJKJ..KK).
//   TX_DATA: tx_ready=1 for exactly the cycle before each payload bit slot, never in a stuff slot.
//    NRZI: 0 toggles J<->K, 1 holds. Ones counter (SYNC final 1 counts) reaching STUFF_LIMIT
//    inserts one 0 slot, counter clears. Stuff after the last bit is still sent before EOP.
//    Slot reached with tx_bit_val=0: tx_underrun pulse, go TX_EOP (packet aborted).
//    Accepted bit with tx_bit_last=1: after its slot (and any stuff) go TX_EOP.
//   TX_EOP: SE0 (00) for EOP_SE0_BITS bit times. TX_J: J one bit time, then oe=0, TX_IDLE.
//   tx_start outside TX_IDLE ignored; tx_bit_val without ready ignored.
//  RX: enabled only while usb_oe=0 (own transmission not decoded); oe rise aborts RX to RX_IDLE silently.
//   Clock recovery: RX counter restarts at 0 on every usb_in change; sample when counter=CLK_PER_BIT/2-1,
//   wraps every CLK_PER_BIT thereafter.
//   RX FSM: RX_IDLE -> RX_SYNC on first J->K transition; RX_SYNC exits on two consecutive K samples
//    (rx_active=1 next cycle); SE0 sample in RX_SYNC -> RX_IDLE, no pulses.
//   RX_DATA: bit=1 if sample equals previous sample, else 0; rx_bit_val strobe same cycle as sample+1.
//    After STUFF_LIMIT ones, next bit 0 is dropped (no strobe); 1 -> rx_stuff_err, rx_active=0, RX_WAIT.
//    SE0 sample -> rx_eop pulse, rx_active=0, RX_WAIT. SE1 (11) sample -> treated as stuff error.
//   RX_WAIT: return RX_IDLE after one J sample.
//  Reset mid-packet: both FSMs to idle next cycle, oe=0, no EOP emitted, no strobes.
// TESTING
//  FS, tx_start, 8 bits 0x2D (LSB first), last on bit 7 -> line K J K J K J K K then NRZI of 0x2D, SE0 8 clk, J 4 clk, oe low.
//  Payload 0xFF then 0x00 -> stuffed 0 after 6th 1 (5 after SYNC's 1 counted), tx_ready gap of one bit slot.
//  tx_bit_val dropped mid-packet -> tx_underrun 1 cycle, SE0 x2 bits, J, TX_IDLE; tx_busy low after.
//  Drive rx line with FS SYNC + NRZI 0xA5 + SE0 2 bits, +/-1 clk jitter per edge -> 8 rx_bit_val, bits 1,0,1,0,0,1,0,1, one rx_eop.
//  Rx seven consecutive 1s after SYNC -> six rx_bit_val ones, rx_stuff_err pulse, no rx_eop, rx_active 0.
//  speed_low=1 same as test 1 -> dp/dm polarity inverted; reset asserted mid-SYNC -> oe 0 and usb_out=J next cycle.

Source files
------------

// File: rtl/usb_nrzi_line_engine.sv
// USB FS/LS line engine: SYNC/NRZI/bit-stuff/EOP serialiser toward the pad and a
// clock-recovering receiver with SYNC detect, NRZI decode, destuffing and EOP/error detect.
module usb_nrzi_line_engine #(
  parameter int unsigned CLK_PER_BIT  = 4,
  parameter int unsigned SYNC_BITS    = 8,
  parameter int unsigned STUFF_LIMIT  = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       speed_low,
  input  logic       tx_start,
  input  logic       tx_bit,
  input  logic       tx_bit_val,
  input  logic       tx_bit_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic [1:0] usb_out,
  output logic       usb_oe,
  input  logic [1:0] usb_in,
  output logic       rx_bit,
  output logic       rx_bit_val,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_stuff_err
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam int unsigned SW = $clog2(SYNC_BITS);
  localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

  localparam logic [CW-1:0] CntLast   = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CntSample = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] SyncLast  = SW'(SYNC_BITS - 1);
  localparam logic [SW-1:0] SyncPen   = SW'(SYNC_BITS - 2);
  localparam logic [OW-1:0] OnesLimit = OW'(STUFF_LIMIT);
  localparam logic [EW-1:0] EopLast   = EW'(EOP_SE0_BITS - 1);

  localparam logic [2:0] TxIdle = 3'd0;
  localparam logic [2:0] TxSync = 3'd1;
  localparam logic [2:0] TxData = 3'd2;
  localparam logic [2:0] TxEop  = 3'd3;
  localparam logic [2:0] TxJ    = 3'd4;

  localparam logic [1:0] RxIdle = 2'd0;
  localparam logic [1:0] RxSync = 2'd1;
  localparam logic [1:0] RxData = 2'd2;
  localparam logic [1:0] RxWait = 2'd3;

  // ---------------------------------------------------------------- transmitter
  logic [2:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic [OW-1:0] tx_ones_q, tx_ones_d;
  logic [EW-1:0] eop_cnt_q, eop_cnt_d;
  logic          line_k_q, line_k_d;
  logic          last_q, last_d;
  logic          tx_spd_q, tx_spd_d;
  logic          underrun_q, underrun_d;
  logic          tx_wrap, tx_data_phase, tx_stuff_due;
  logic [1:0]    tx_j, tx_k;

  assign tx_wrap       = (tx_cnt_q == CntLast);
  assign tx_stuff_due  = (tx_ones_q == OnesLimit);
  // The final SYNC bit's boundary behaves like a data boundary: next slot is payload or stuff.
  assign tx_data_phase = (tx_state_q == TxData) ||
                         ((tx_state_q == TxSync) && (sync_cnt_q == SyncLast));
  assign tx_ready      = tx_wrap && tx_data_phase && !tx_stuff_due && !last_q;
  assign tx_busy       = (tx_state_q != TxIdle);
  assign usb_oe        = tx_busy;
  assign tx_underrun   = underrun_q;
  assign tx_j          = tx_spd_q ? 2'b01 : 2'b10;
  assign tx_k          = ~tx_j;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    sync_cnt_d = sync_cnt_q;
    tx_ones_d  = tx_ones_q;
    eop_cnt_d  = eop_cnt_q;
    line_k_d   = line_k_q;
    last_d     = last_q;
    tx_spd_d   = tx_spd_q;
    underrun_d = 1'b0;
    if (tx_state_q == TxIdle) begin
      tx_spd_d = speed_low;
      if (tx_start) begin
        tx_state_d = TxSync;
        tx_cnt_d   = '0;
        sync_cnt_d = '0;
        tx_ones_d  = '0;
        line_k_d   = 1'b1;
        last_d     = 1'b0;
      end
    end else begin
      tx_cnt_d = tx_wrap ? '0 : tx_cnt_q + CW'(1);
      if (tx_wrap) begin
        if (tx_data_phase) begin
          tx_state_d = TxData;
          if (tx_stuff_due) begin
            line_k_d  = ~line_k_q;
            tx_ones_d = '0;
          end else if (last_q) begin
            tx_state_d = TxEop;
            eop_cnt_d  = '0;
          end else if (tx_bit_val) begin
            last_d = tx_bit_last;
            if (tx_bit) begin
              tx_ones_d = tx_ones_q + OW'(1);
            end else begin
              line_k_d  = ~line_k_q;
              tx_ones_d = '0;
            end
          end else begin
            tx_state_d = TxEop;
            eop_cnt_d  = '0;
            underrun_d = 1'b1;
          end
        end else begin
          case (tx_state_q)
            TxSync: begin
              sync_cnt_d = sync_cnt_q + SW'(1);
              if (sync_cnt_q == SyncPen) begin
                tx_ones_d = OW'(1);
              end else begin
                line_k_d = ~line_k_q;
              end
            end
            TxEop: begin
              if (eop_cnt_q == EopLast) begin
                tx_state_d = TxJ;
              end else begin
                eop_cnt_d = eop_cnt_q + EW'(1);
              end
            end
            default: tx_state_d = TxIdle;
          endcase
        end
      end
    end
  end

  always_comb begin
    case (tx_state_q)
      TxSync, TxData: usb_out = line_k_q ? tx_k : tx_j;
      TxEop:          usb_out = 2'b00;
      default:        usb_out = tx_j;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      sync_cnt_q <= '0;
      tx_ones_q  <= '0;
      eop_cnt_q  <= '0;
      line_k_q   <= 1'b0;
      last_q     <= 1'b0;
      tx_spd_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      tx_ones_q  <= tx_ones_d;
      eop_cnt_q  <= eop_cnt_d;
      line_k_q   <= line_k_d;
      last_q     <= last_d;
      tx_spd_q   <= tx_spd_d;
      underrun_q <= underrun_d;
    end
  end

  // ---------------------------------------------------------------- receiver
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [1:0]    in_q;
  logic [1:0]    prev_q, prev_d;
  logic [OW-1:0] rx_ones_q, rx_ones_d;
  logic          rx_spd_q, rx_spd_d;
  logic          rx_bit_q, rx_bit_d;
  logic          rx_val_q, rx_val_d;
  logic          rx_eop_q, rx_eop_d;
  logic          rx_err_q, rx_err_d;
  logic          rx_sample, rx_same;
  logic [1:0]    rx_j, rx_k;

  assign rx_j         = rx_spd_q ? 2'b01 : 2'b10;
  assign rx_k         = ~rx_j;
  assign rx_sample    = (rx_cnt_q == CntSample);
  assign rx_same      = (usb_in == prev_q);
  assign rx_bit       = rx_bit_q;
  assign rx_bit_val   = rx_val_q;
  assign rx_active    = (rx_state_q == RxData);
  assign rx_eop       = rx_eop_q;
  assign rx_stuff_err = rx_err_q;

  // Every line edge realigns the bit timer so sampling stays centred under jitter.
  always_comb begin
    if (usb_in != in_q) begin
      rx_cnt_d = '0;
    end else begin
      rx_cnt_d = (rx_cnt_q == CntLast) ? '0 : rx_cnt_q + CW'(1);
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    prev_d     = prev_q;
    rx_ones_d  = rx_ones_q;
    rx_spd_d   = rx_spd_q;
    rx_bit_d   = rx_bit_q;
    rx_val_d   = 1'b0;
    rx_eop_d   = 1'b0;
    rx_err_d   = 1'b0;
    if (usb_oe) begin
      rx_state_d = RxIdle;
      rx_ones_d  = '0;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          rx_spd_d = speed_low;
          if ((in_q == rx_j) && (usb_in == rx_k)) begin
            rx_state_d = RxSync;
            prev_d     = rx_j;
          end
        end
        RxSync: begin
          if (rx_sample) begin
            prev_d = usb_in;
            if (usb_in == 2'b00) begin
              rx_state_d = RxIdle;
            end else if ((usb_in == rx_k) && (prev_q == rx_k)) begin
              rx_state_d = RxData;
              rx_ones_d  = '0;
            end
          end
        end
        RxData: begin
          if (rx_sample) begin
            prev_d = usb_in;
            if (usb_in == 2'b00) begin
              rx_eop_d   = 1'b1;
              rx_state_d = RxWait;
            end else if ((usb_in == 2'b11) || ((rx_ones_q == OnesLimit) && rx_same)) begin
              rx_err_d   = 1'b1;
              rx_state_d = RxWait;
            end else if (rx_ones_q == OnesLimit) begin
              rx_ones_d = '0;
            end else begin
              rx_val_d  = 1'b1;
              rx_bit_d  = rx_same;
              rx_ones_d = rx_same ? rx_ones_q + OW'(1) : '0;
            end
          end
        end
        default: begin
          if (rx_sample && (usb_in == rx_j)) begin
            rx_state_d = RxIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      in_q       <= 2'b00;
      prev_q     <= 2'b00;
      rx_ones_q  <= '0;
      rx_spd_q   <= 1'b0;
      rx_bit_q   <= 1'b0;
      rx_val_q   <= 1'b0;
      rx_eop_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      in_q       <= usb_in;
      prev_q     <= prev_d;
      rx_ones_q  <= rx_ones_d;
      rx_spd_q   <= rx_spd_d;
      rx_bit_q   <= rx_bit_d;
      rx_val_q   <= rx_val_d;
      rx_eop_q   <= rx_eop_d;
      rx_err_q   <= rx_err_d;
    end
  end

endmodule
